bsg_manycore_pkt_out_fifo_credit: RTL and testbench
===================================================

Name: bsg_manycore_pkt_out_fifo_credit

Overview:
- Sits directly downstream of the manycore packet encoder.
- Buffers outgoing remote-store packets in a small FIFO and injects them into the mesh network over a valid/ready link.
- Gates injection on an outstanding-store credit counter that the network replenishes with return pulses.
- Exposes idle status so the core can implement a store fence.

Parameters:
- x_cord_width_p, 5, width of X coordinate fields.
- y_cord_width_p, 5, width of Y coordinate fields.
- data_width_p, 32, packet data field width.
- addr_width_p, 32, packet address field width.
- els_p, 4, FIFO depth in packets; must be ≥2, need not be a power of two.
- max_out_credits_p, 16, maximum outstanding stores; must be ≥1.
- packet_width_lp, 6+addr_width_p+data_width_p+2*(x_cord_width_p+y_cord_width_p), derived; not overridden.
- credit_width_lp, $clog2(max_out_credits_p+1), derived.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  encoder packet valid.
- data_i  in  packet_width_lp  encoded packet, opaque to this block.
- ready_o  out  1  FIFO can accept a packet this cycle.
- v_o  out  1  packet offered to network.
- data_o  out  packet_width_lp  head packet.
- ready_i  in  1  network accepts packet.
- credit_i  in  1  one store completed; return one credit.
- out_credits_o  out  credit_width_lp  credits currently available.
- idle_o  out  1  FIFO empty and all credits returned.

Behaviour:
- Reset (asserts immediately, independent of clk_i, including mid-transfer):
  - count, rd_ptr, wr_ptr cleared to 0; credit counter set to max_out_credits_p.
  - Outputs: v_o=0, ready_o=1, data_o=0, out_credits_o=max_out_credits_p, idle_o=1.
  - FIFO storage is not reset.
  - Packets in flight at reset are discarded; no credit is recovered beyond the reload to max.
- Enqueue:
  - Occurs when v_i & ready_o.
  - ready_o = (count != els_p), from registered state only; no combinational path from ready_i.
  - When full, no enqueue is accepted even if a dequeue happens the same cycle.
- Dequeue:
  - Occurs when v_o & ready_i.
  - v_o = (count != 0) & (credits != 0).
  - data_o = head entry when count != 0, else all zeros.
  - v_o is not required to stay asserted while ready_i is low; if it stays asserted, data_o is stable.
- Latency:
  - A packet enqueued in cycle t may appear on v_o no earlier than cycle t+1; there is no bypass.
  - Minimum one cycle, best-case throughput one packet per cycle.
- Pointers:
  - wr_ptr advances on enqueue, rd_ptr on dequeue.
  - Each wraps from els_p-1 to 0, so non-power-of-two depths are valid.
  - count += enq, −= deq; simultaneous enqueue and dequeue leaves count unchanged.
- Credits:
  - Decrement by 1 on dequeue; increment by 1 on credit_i.
  - Simultaneous dequeue and credit_i leaves the counter unchanged.
  - At credits=0, v_o is forced low; the packet stays at the head and the FIFO keeps accepting until full.
  - credit_i while credits==max_out_credits_p (with no simultaneous dequeue) is a protocol error: counter saturates at max and a simulation-only $error fires.
  - Dequeue can never occur at credits=0 because v_o is gated.
- out_credits_o = credit counter, registered.
- idle_o = (count==0) & (credits==max_out_credits_p), combinational from registered state.
- Simulation-only checks:
  - v_i asserted while ready_o=0 → $error (packet dropped, no state change).
  - credit_i overflow → $error (see Credits).

Test Plan:
- Reset then idle: release reset_n_i, no stimulus → v_o=0, ready_o=1, out_credits_o=16, idle_o=1, data_o=0.
- Single packet: v_i=1 with data_i=A at cycle 0, ready_i=1 → v_o=1 with data_o=A at cycle 1. Then out_credits_o=15 and idle_o=0; credit_i pulse → out_credits_o=16, idle_o=1.
- Fill and backpressure: ready_i=0, push 5 packets with els_p=4 → ready_o=0 after the 4th, 5th push flagged. Then ready_i=1 → packets drain in order 1..4, one per cycle.
- Credit exhaustion: max_out_credits_p=2, push 3 packets, ready_i=1, no credit_i → exactly 2 dequeued, v_o=0 with the 3rd held at head. A credit_i pulse → 3rd sent next cycle, out_credits_o=0.
- Simultaneous events:
  - Full FIFO, enq+deq same cycle → enqueue refused, count=3.
  - Dequeue and credit_i in the same cycle → out_credits_o unchanged.
- Async reset mid-stream: assert reset_n_i between clock edges with 3 packets queued and credits=10 → outputs return to reset values immediately; after release the FIFO is empty and out_credits_o=16.
- Wrap-around: els_p=3, stream 10 packets with random ready_i → output order equals input order, no loss or duplication.

Source files
------------

// File: rtl/bsg_manycore_pkt_out_fifo_credit.sv
// Outgoing remote-store packet FIFO with outstanding-store credit gating.
// Ports: encoder v_i/data_i/ready_o in, network v_o/data_o/ready_i out, credit_i return, out_credits_o/idle_o status.
module bsg_manycore_pkt_out_fifo_credit #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int els_p = 4,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp =
    6 + addr_width_p + data_width_p
    + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int credit_width_lp =
    $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [packet_width_lp-1:0] data_o,
  input  logic                       ready_i,
  input  logic                       credit_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       idle_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp =
    ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp =
    cnt_w_lp'(els_p);
  localparam logic [credit_width_lp-1:0] max_cred_lp =
    credit_width_lp'(max_out_credits_p);

  logic [packet_width_lp-1:0] r_mem [els_p];
  logic [ptr_w_lp-1:0]        r_rd_ptr;
  logic [ptr_w_lp-1:0]        r_wr_ptr;
  logic [cnt_w_lp-1:0]        r_count;
  logic [credit_width_lp-1:0] r_credits;

  logic                       w_not_empty;
  logic                       w_has_credit;
  logic                       w_enq;
  logic                       w_deq;
  logic                       w_cred_full;
  logic [cnt_w_lp-1:0]        w_count_n;
  logic [credit_width_lp-1:0] w_credits_n;
  logic [ptr_w_lp-1:0]        w_rd_ptr_n;
  logic [ptr_w_lp-1:0]        w_wr_ptr_n;

  // explicit wrap keeps non-power-of-two depths correct
  function automatic logic [ptr_w_lp-1:0] ptr_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  assign w_not_empty  = (r_count != '0);
  assign w_has_credit = (r_credits != '0);
  assign w_cred_full  = (r_credits == max_cred_lp);

  // ready depends only on registered count, never on ready_i
  assign ready_o = (r_count != full_cnt_lp);
  assign v_o     = w_not_empty & w_has_credit;
  assign data_o  = w_not_empty ? r_mem[r_rd_ptr] : '0;

  assign w_enq = v_i & ready_o;
  assign w_deq = v_o & ready_i;

  assign out_credits_o = r_credits;
  assign idle_o        = ~w_not_empty & w_cred_full;

  always_comb begin
    w_count_n   = r_count;
    w_credits_n = r_credits;
    w_rd_ptr_n  = r_rd_ptr;
    w_wr_ptr_n  = r_wr_ptr;
    unique case ({w_enq, w_deq})
      2'b10:   w_count_n = r_count + 1'b1;
      2'b01:   w_count_n = r_count - 1'b1;
      default: w_count_n = r_count;
    endcase
    if (w_enq) w_wr_ptr_n = ptr_inc(r_wr_ptr);
    if (w_deq) w_rd_ptr_n = ptr_inc(r_rd_ptr);
    // a return pulse at max saturates rather than wrapping
    if (w_deq && !credit_i)
      w_credits_n = r_credits - 1'b1;
    else if (credit_i && !w_deq && !w_cred_full)
      w_credits_n = r_credits + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_credits <= max_cred_lp;
    end else begin
      r_rd_ptr  <= w_rd_ptr_n;
      r_wr_ptr  <= w_wr_ptr_n;
      r_count   <= w_count_n;
      r_credits <= w_credits_n;
    end
  end

  // storage needs no reset: count gates every read
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= data_i;
  end

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(v_i && !ready_o))
        else $error("pkt dropped: v_i while full");
      assert (!(credit_i && !w_deq && w_cred_full))
        else $error("credit return overflow");
    end
  end

endmodule

// File: tb/tb_bsg_manycore_pkt_out_fifo_credit.sv
// Scoreboard bench for the packet-out FIFO with credit gating.
// Instance a: default depth/credits; instance b: els_p=3, max_out_credits_p=2.
module tb_bsg_manycore_pkt_out_fifo_credit;

  localparam int PW = 90;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_v_i, a_ready_o, a_v_o, a_ready_i, a_credit_i, a_idle;
  logic [PW-1:0] a_data_i, a_data_o;
  logic [4:0] a_cred;

  logic b_v_i, b_ready_o, b_v_o, b_ready_i, b_credit_i, b_idle;
  logic [PW-1:0] b_data_i, b_data_o;
  logic [1:0] b_cred;

  bsg_manycore_pkt_out_fifo_credit u_dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(a_v_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .v_o(a_v_o), .data_o(a_data_o), .ready_i(a_ready_i),
    .credit_i(a_credit_i), .out_credits_o(a_cred),
    .idle_o(a_idle)
  );

  bsg_manycore_pkt_out_fifo_credit #(
    .els_p(3), .max_out_credits_p(2)
  ) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready_o),
    .v_o(b_v_o), .data_o(b_data_o), .ready_i(b_ready_i),
    .credit_i(b_credit_i), .out_credits_o(b_cred),
    .idle_o(b_idle)
  );

  int checks = 0;
  int errors = 0;
  int a_deq = 0;
  int b_deq = 0;
  int b_out = 0;
  logic [PW-1:0] qa[$];
  logic [PW-1:0] qb[$];

  function automatic logic [PW-1:0] pkt(int k);
    return {26'h2ABCDEF ^ 26'(k), 32'(k * 7 + 3),
            32'hC0DE0000 | 32'(k)};
  endfunction

  task automatic chk(string nm, logic [PW-1:0] act,
                     logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitors: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst_n && a_v_o && a_ready_i) begin
      a_deq++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra: got %0h expected none", a_data_o);
      end else chk("a_data", a_data_o, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_v_o && b_ready_i) begin
      b_deq++;
      b_out++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra: got %0h expected none", b_data_o);
      end else chk("b_data", b_data_o, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int sent;
    a_v_i = 0; a_data_i = '0; a_ready_i = 0; a_credit_i = 0;
    b_v_i = 0; b_data_i = '0; b_ready_i = 0; b_credit_i = 0;

    // reset and idle
    repeat (2) cyc();
    chk("rst_v", a_v_o, 0);
    chk("rst_cred", a_cred, 16);
    rst_n = 1;
    cyc();
    chk("idle_v", a_v_o, 0);
    chk("idle_ready", a_ready_o, 1);
    chk("idle_cred", a_cred, 16);
    chk("idle_idle", a_idle, 1);
    chk("idle_data", a_data_o, 0);
    chk("b_idle_cred", b_cred, 2);
    chk("b_idle_idle", b_idle, 1);

    // single packet, no bypass
    a_ready_i = 1;
    a_v_i = 1; a_data_i = pkt(1); qa.push_back(pkt(1));
    chk("nobypass", a_v_o, 0);
    cyc();
    a_v_i = 0;
    chk("single_v", a_v_o, 1);
    chk("single_cred_pre", a_cred, 16);
    cyc();
    chk("single_cred", a_cred, 15);
    chk("single_idle", a_idle, 0);
    chk("single_v_after", a_v_o, 0);
    a_credit_i = 1;
    cyc();
    a_credit_i = 0;
    chk("single_ret_cred", a_cred, 16);
    chk("single_ret_idle", a_idle, 1);

    // fill with backpressure
    a_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      chk("fill_ready", a_ready_o, 1);
      a_v_i = 1; a_data_i = pkt(10 + k);
      qa.push_back(pkt(10 + k));
      cyc();
    end
    a_v_i = 0;
    chk("full_ready", a_ready_o, 0);
    cyc();
    chk("full_v", a_v_o, 1);
    chk("full_head", a_data_o, pkt(10));
    // dequeue pending while full: still not ready
    a_ready_i = 1;
    chk("full_deq_ready", a_ready_o, 0);
    cyc();
    chk("after_deq_ready", a_ready_o, 1);
    chk("after_deq_q", PW'(qa.size()), 3);
    repeat (3) cyc();
    a_ready_i = 0;
    chk("drain_q", PW'(qa.size()), 0);
    chk("drain_v", a_v_o, 0);
    chk("drain_cred", a_cred, 12);

    // dequeue and credit return together
    a_v_i = 1; a_data_i = pkt(20); qa.push_back(pkt(20));
    cyc();
    a_v_i = 0; a_ready_i = 1; a_credit_i = 1;
    chk("sim_cred_pre", a_cred, 12);
    cyc();
    a_ready_i = 0;
    chk("sim_cred", a_cred, 12);
    chk("sim_q", PW'(qa.size()), 0);
    repeat (4) cyc();
    a_credit_i = 0;
    chk("ret_cred", a_cred, 16);
    chk("ret_idle", a_idle, 1);

    // async reset mid-stream with 3 queued and 10 credits
    a_ready_i = 1;
    for (int k = 0; k < 6; k++) begin
      a_v_i = 1; a_data_i = pkt(30 + k);
      qa.push_back(pkt(30 + k));
      cyc();
    end
    a_v_i = 0;
    cyc();
    a_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      a_v_i = 1; a_data_i = pkt(40 + k);
      qa.push_back(pkt(40 + k));
      cyc();
    end
    a_v_i = 0;
    chk("pre_rst_cred", a_cred, 10);
    chk("pre_rst_v", a_v_o, 1);
    chk("pre_rst_ready", a_ready_o, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_v", a_v_o, 0);
    chk("arst_ready", a_ready_o, 1);
    chk("arst_data", a_data_o, 0);
    chk("arst_cred", a_cred, 16);
    chk("arst_idle", a_idle, 1);
    qa.delete();
    cyc();
    rst_n = 1;
    cyc();
    chk("post_rst_v", a_v_o, 0);
    chk("post_rst_cred", a_cred, 16);
    a_ready_i = 1;
    a_v_i = 1; a_data_i = pkt(50); qa.push_back(pkt(50));
    cyc();
    a_v_i = 0;
    cyc();
    a_ready_i = 0;
    chk("post_rst_q", PW'(qa.size()), 0);
    chk("post_rst_cred2", a_cred, 15);

    // credit exhaustion on b
    st = b_deq;
    b_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      b_v_i = 1; b_data_i = pkt(60 + k);
      qb.push_back(pkt(60 + k));
      cyc();
    end
    b_v_i = 0;
    chk("exh_v", b_v_o, 0);
    chk("exh_cred", b_cred, 0);
    chk("exh_head", b_data_o, pkt(62));
    repeat (3) cyc();
    chk("exh_hold_v", b_v_o, 0);
    chk("exh_deq", PW'(b_deq - st), 2);
    b_credit_i = 1;
    cyc();
    b_credit_i = 0;
    chk("exh_ret_v", b_v_o, 1);
    chk("exh_ret_cred", b_cred, 1);
    cyc();
    b_ready_i = 0;
    chk("exh_last_cred", b_cred, 0);
    chk("exh_last_v", b_v_o, 0);
    chk("exh_deq3", PW'(b_deq - st), 3);
    chk("exh_q", PW'(qb.size()), 0);
    b_credit_i = 1;
    repeat (2) cyc();
    b_credit_i = 0;
    chk("exh_full_cred", b_cred, 2);
    chk("exh_idle", b_idle, 1);

    // wrap-around on depth 3 with random backpressure
    st = b_deq;
    b_out = 0;
    sent = 0;
    for (int c = 0; c < 400 && (b_deq - st) < 10; c++) begin
      b_ready_i = 1'($urandom_range(0, 1));
      b_credit_i = (b_out > 0);
      if (b_credit_i) b_out--;
      if (sent < 10 && b_ready_o) begin
        b_v_i = 1; b_data_i = pkt(70 + sent);
        qb.push_back(pkt(70 + sent));
        sent++;
      end else b_v_i = 0;
      cyc();
    end
    b_v_i = 0; b_ready_i = 0;
    chk("wrap_deq", PW'(b_deq - st), 10);
    chk("wrap_q", PW'(qb.size()), 0);
    for (int c = 0; c < 4; c++) begin
      b_credit_i = (b_out > 0);
      if (b_credit_i) b_out--;
      cyc();
    end
    b_credit_i = 0;
    chk("wrap_cred", b_cred, 2);
    chk("wrap_idle", b_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
